// File: rtl/jedro_1_trap_ctrl_pkg.sv
// Shared constants and types for the jedro_1 trap sequencer:
// interrupt/exception cause codes, mtvec modes, FSM state encoding
// and the fixed interrupt priority helper.
package jedro_1_trap_ctrl_pkg;

  // Interrupt cause codes double as their bit position in mip/mie.
  localparam logic [4:0] MCAUSE_IRQ_MEI = 5'd11;
  localparam logic [4:0] MCAUSE_IRQ_MSI = 5'd3;
  localparam logic [4:0] MCAUSE_IRQ_MTI = 5'd7;

  // Synchronous exception codes (mcause with interrupt bit clear).
  localparam logic [4:0] EXC_INSTR_MISALIGN = 5'd0;
  localparam logic [4:0] EXC_INSTR_ACCESS   = 5'd1;
  localparam logic [4:0] EXC_ILLEGAL_INSTR  = 5'd2;
  localparam logic [4:0] EXC_BREAKPOINT     = 5'd3;
  localparam logic [4:0] EXC_LOAD_MISALIGN  = 5'd4;
  localparam logic [4:0] EXC_LOAD_ACCESS    = 5'd5;
  localparam logic [4:0] EXC_STORE_MISALIGN = 5'd6;
  localparam logic [4:0] EXC_STORE_ACCESS   = 5'd7;
  localparam logic [4:0] EXC_ECALL_M        = 5'd11;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [2:0] {
    TRAP_IDLE  = 3'd0,
    TRAP_DRAIN = 3'd1,
    TRAP_SAVE  = 3'd2,
    TRAP_JUMP  = 3'd3,
    TRAP_RET   = 3'd4
  } trap_state_e;

  // Fixed machine-level priority: external > software > timer.
  function automatic logic [4:0] irq_prio_code(input logic mei, input logic msi, input logic mti);
    logic [4:0] code;
    code = '0;
    if (mei)      code = MCAUSE_IRQ_MEI;
    else if (msi) code = MCAUSE_IRQ_MSI;
    else if (mti) code = MCAUSE_IRQ_MTI;
    return code;
  endfunction

endpackage

// File: rtl/jedro_1_trap_ctrl_if.sv
// Pipeline / CSR-file side bundle of the trap sequencer.
// slave = trap controller view, master = pipeline + CSR view.
interface jedro_1_trap_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  irq_ext_i;
  logic                  irq_sw_i;
  logic                  irq_tmr_i;
  logic                  mstatus_mie_i;
  logic [DATA_WIDTH-1:0] mie_i;
  logic [DATA_WIDTH-1:0] mtvec_i;
  logic [DATA_WIDTH-1:0] mepc_i;
  logic                  exc_i;
  logic [4:0]            exc_cause_i;
  logic [DATA_WIDTH-1:0] exc_pc_i;
  logic                  mret_i;
  logic [DATA_WIDTH-1:0] next_pc_i;
  logic                  pipe_empty_i;

  logic                  stall_fetch_o;
  logic                  flush_o;
  logic                  jmp_o;
  logic [DATA_WIDTH-1:0] jmp_addr_o;
  logic                  mepc_we_o;
  logic                  mcause_we_o;
  logic [DATA_WIDTH-1:0] mepc_o;
  logic [DATA_WIDTH-1:0] mcause_o;
  logic                  mstatus_trap_o;
  logic                  mstatus_mret_o;
  logic [DATA_WIDTH-1:0] mip_o;

  modport slave (
    input  irq_ext_i, irq_sw_i, irq_tmr_i, mstatus_mie_i, mie_i, mtvec_i, mepc_i,
           exc_i, exc_cause_i, exc_pc_i, mret_i, next_pc_i, pipe_empty_i,
    output stall_fetch_o, flush_o, jmp_o, jmp_addr_o, mepc_we_o, mcause_we_o,
           mepc_o, mcause_o, mstatus_trap_o, mstatus_mret_o, mip_o
  );

  modport master (
    output irq_ext_i, irq_sw_i, irq_tmr_i, mstatus_mie_i, mie_i, mtvec_i, mepc_i,
           exc_i, exc_cause_i, exc_pc_i, mret_i, next_pc_i, pipe_empty_i,
    input  stall_fetch_o, flush_o, jmp_o, jmp_addr_o, mepc_we_o, mcause_we_o,
           mepc_o, mcause_o, mstatus_trap_o, mstatus_mret_o, mip_o
  );
endinterface

// File: rtl/jedro_1_trap_ctrl_irq_prio.sv
// Combinational interrupt priority encoder: enabled-and-pending bits
// in, "something to take" flag and winning cause code out.
module jedro_1_trap_ctrl_irq_prio
  import jedro_1_trap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_mip,
  input  logic [DATA_WIDTH-1:0] i_mie,
  output logic                  o_valid,
  output logic [4:0]            o_code
);

  logic [DATA_WIDTH-1:0] w_pend;
  logic                  w_unused;

  assign w_pend   = i_mip & i_mie;
  assign o_valid  = w_pend[MCAUSE_IRQ_MEI] | w_pend[MCAUSE_IRQ_MSI] | w_pend[MCAUSE_IRQ_MTI];
  assign o_code   = irq_prio_code(w_pend[MCAUSE_IRQ_MEI], w_pend[MCAUSE_IRQ_MSI],
                                  w_pend[MCAUSE_IRQ_MTI]);
  // Only bits 3/7/11 carry machine interrupts; the rest are don't-care.
  assign w_unused = ^w_pend;

endmodule

// File: rtl/jedro_1_trap_ctrl.sv
// jedro_1 trap sequencer. Converts pending interrupts, synchronous
// exceptions and MRET into stall -> drain -> CSR save -> redirect/flush.
// Holds only the latched cause/epc; all CSR storage lives in the CSR file.
module jedro_1_trap_ctrl
  import jedro_1_trap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int IRQ_SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  jedro_1_trap_ctrl_if.slave   bus
);

  trap_state_e                      r_state, w_state_nxt;
  logic [IRQ_SYNC_STAGES-1:0][2:0]  r_irq_sync;   // {ext, tmr, sw} per stage
  logic [DATA_WIDTH-1:0]            r_cause, w_cause_nxt;
  logic [DATA_WIDTH-1:0]            r_epc, w_epc_nxt;
  logic [DATA_WIDTH-1:0]            w_mip;
  logic                             w_irq_vld;
  logic [4:0]                       w_irq_code;
  logic                             w_irq_take;
  logic [DATA_WIDTH-1:0]            w_base;
  logic [DATA_WIDTH-1:0]            w_vec_off;
  logic [DATA_WIDTH-1:0]            w_exc_cause;
  logic [DATA_WIDTH-1:0]            w_irq_cause;

  // Shift each raw irq line through IRQ_SYNC_STAGES flops before use.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_irq_sync <= '0;
    end else begin
      r_irq_sync[0] <= {bus.irq_ext_i, bus.irq_tmr_i, bus.irq_sw_i};
      for (int i = 1; i < IRQ_SYNC_STAGES; i++) r_irq_sync[i] <= r_irq_sync[i-1];
    end
  end

  // Place synchronized pending bits at their mip positions.
  always_comb begin
    w_mip                 = '0;
    w_mip[MCAUSE_IRQ_MEI] = r_irq_sync[IRQ_SYNC_STAGES-1][2];
    w_mip[MCAUSE_IRQ_MTI] = r_irq_sync[IRQ_SYNC_STAGES-1][1];
    w_mip[MCAUSE_IRQ_MSI] = r_irq_sync[IRQ_SYNC_STAGES-1][0];
  end

  assign bus.mip_o = w_mip;

  jedro_1_trap_ctrl_irq_prio #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_irq_prio (
    .i_mip   (w_mip),
    .i_mie   (bus.mie_i),
    .o_valid (w_irq_vld),
    .o_code  (w_irq_code)
  );

  assign w_irq_take  = bus.mstatus_mie_i & w_irq_vld;
  assign w_exc_cause = {{(DATA_WIDTH-5){1'b0}}, bus.exc_cause_i};
  assign w_irq_cause = {1'b1, {(DATA_WIDTH-6){1'b0}}, w_irq_code};

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  // The add is plain modular arithmetic, so a base near the top wraps.
  assign w_base    = {bus.mtvec_i[DATA_WIDTH-1:2], 2'b00};
  assign w_vec_off = ((bus.mtvec_i[1:0] == MTVEC_MODE_VECTORED) && r_cause[DATA_WIDTH-1])
                     ? {{(DATA_WIDTH-7){1'b0}}, r_cause[4:0], 2'b00} : '0;

  // State, cause and epc registers; async reset drops back to IDLE.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= TRAP_IDLE;
      r_cause <= '0;
      r_epc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
      r_epc   <= w_epc_nxt;
    end
  end

  // Next-state and strobe decode; strobes and their data are zero unless active.
  always_comb begin
    w_state_nxt        = r_state;
    w_cause_nxt        = r_cause;
    w_epc_nxt          = r_epc;
    bus.stall_fetch_o  = 1'b0;
    bus.flush_o        = 1'b0;
    bus.jmp_o          = 1'b0;
    bus.jmp_addr_o     = '0;
    bus.mepc_we_o      = 1'b0;
    bus.mcause_we_o    = 1'b0;
    bus.mepc_o         = '0;
    bus.mcause_o       = '0;
    bus.mstatus_trap_o = 1'b0;
    bus.mstatus_mret_o = 1'b0;

    unique case (r_state)
      TRAP_IDLE: begin
        if (bus.exc_i) begin
          // Faulting instr is already known; kill younger instrs right away.
          bus.flush_o = 1'b1;
          w_cause_nxt = w_exc_cause;
          w_epc_nxt   = bus.exc_pc_i;
          w_state_nxt = TRAP_SAVE;
        end else if (bus.mret_i) begin
          w_state_nxt = TRAP_RET;
        end else if (w_irq_take) begin
          // Cause is frozen here; later irq changes do not affect this trap.
          w_cause_nxt = w_irq_cause;
          w_state_nxt = TRAP_DRAIN;
        end
      end

      TRAP_DRAIN: begin
        bus.stall_fetch_o = 1'b1;
        if (bus.exc_i) begin
          // A retiring instr faulted while draining: the exception wins.
          bus.flush_o = 1'b1;
          w_cause_nxt = w_exc_cause;
          w_epc_nxt   = bus.exc_pc_i;
          w_state_nxt = TRAP_SAVE;
        end else if (bus.pipe_empty_i) begin
          w_epc_nxt   = bus.next_pc_i;
          w_state_nxt = TRAP_SAVE;
        end
      end

      TRAP_SAVE: begin
        bus.stall_fetch_o  = 1'b1;
        bus.mepc_we_o      = 1'b1;
        bus.mcause_we_o    = 1'b1;
        bus.mepc_o         = r_epc;
        bus.mcause_o       = r_cause;
        bus.mstatus_trap_o = 1'b1;
        w_state_nxt        = TRAP_JUMP;
      end

      TRAP_JUMP: begin
        bus.jmp_o      = 1'b1;
        bus.flush_o    = 1'b1;
        bus.jmp_addr_o = w_base + w_vec_off;
        w_state_nxt    = TRAP_IDLE;
      end

      TRAP_RET: begin
        bus.jmp_o          = 1'b1;
        bus.flush_o        = 1'b1;
        bus.mstatus_mret_o = 1'b1;
        bus.jmp_addr_o     = bus.mepc_i;
        w_state_nxt        = TRAP_IDLE;
      end

      default: w_state_nxt = TRAP_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jedro_1_trap_ctrl.sv
// Self-checking bench for jedro_1_trap_ctrl: directed cases plus
// randomized trap/return scenarios against a behavioural model.
module tb_jedro_1_trap_ctrl;

  localparam int SYNC = 2;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  jedro_1_trap_ctrl_if #(.DATA_WIDTH(32)) bus ();

  jedro_1_trap_ctrl #(
    .DATA_WIDTH      (32),
    .IRQ_SYNC_STAGES (SYNC)
  ) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h @%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [4:0] exp_irq_code(input logic [2:0] lines, input logic [31:0] mie);
    if (lines[2] && mie[11]) return 5'd11;
    if (lines[0] && mie[3])  return 5'd3;
    if (lines[1] && mie[7])  return 5'd7;
    return 5'd0;
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] mtvec, input bit is_irq,
                                             input logic [4:0] code);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
    if (is_irq && mtvec[1:0] == 2'b01) return base + 32'(code) * 4;
    return base;
  endfunction

  function automatic logic [31:0] exp_mip(input logic [2:0] lines);
    return (32'(lines[2]) << 11) | (32'(lines[1]) << 7) | (32'(lines[0]) << 3);
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk_i); #1;
    bus.exc_i  = 1'b0;
    bus.mret_i = 1'b0;
  endtask

  task automatic set_lines(input logic [2:0] l);
    {bus.irq_ext_i, bus.irq_tmr_i, bus.irq_sw_i} = l;
  endtask

  // Starts at the sampling point of the cycle that triggered the save.
  task automatic expect_trap(input string tag, input logic [31:0] cause, input logic [31:0] epc,
                             input logic [31:0] tgt, input int lat);
    int cyc = 0;
    do begin tick(); @(negedge clk_i); cyc++; end
    while (bus.mepc_we_o !== 1'b1 && cyc < 60);
    chk({tag, "_save_lat"}, cyc, lat);
    chk({tag, "_mepc_we"}, 32'(bus.mepc_we_o), 1);
    chk({tag, "_mcause_we"}, 32'(bus.mcause_we_o), 1);
    chk({tag, "_trap"}, 32'(bus.mstatus_trap_o), 1);
    chk({tag, "_save_stall"}, 32'(bus.stall_fetch_o), 1);
    chk({tag, "_mepc"}, bus.mepc_o, epc);
    chk({tag, "_mcause"}, bus.mcause_o, cause);
    tick();
    bus.mstatus_mie_i = 1'b0;   // CSR file: MIE <= 0 on trap
    @(negedge clk_i);
    chk({tag, "_jmp"}, 32'(bus.jmp_o), 1);
    chk({tag, "_jflush"}, 32'(bus.flush_o), 1);
    chk({tag, "_jaddr"}, bus.jmp_addr_o, tgt);
    chk({tag, "_jwe"}, 32'(bus.mepc_we_o), 0);
    tick(); @(negedge clk_i);
    chk({tag, "_idle"}, 32'(bus.jmp_o | bus.stall_fetch_o), 0);
  endtask

  task automatic do_exc(input string tag, input logic [4:0] ec, input logic [31:0] pc);
    tick();
    bus.exc_i = 1'b1; bus.exc_cause_i = ec; bus.exc_pc_i = pc;
    @(negedge clk_i);
    chk({tag, "_flush"}, 32'(bus.flush_o), 1);
    chk({tag, "_nojmp"}, 32'(bus.jmp_o), 0);
    expect_trap(tag, 32'(ec), pc, exp_target(bus.mtvec_i, 1'b0, ec), 1);
  endtask

  task automatic do_mret(input string tag, input logic [31:0] epc);
    tick();
    bus.mret_i = 1'b1; bus.mepc_i = epc;
    @(negedge clk_i);
    chk({tag, "_pre"}, 32'(bus.jmp_o), 0);
    tick(); @(negedge clk_i);
    chk({tag, "_jmp"}, 32'(bus.jmp_o), 1);
    chk({tag, "_addr"}, bus.jmp_addr_o, epc);
    chk({tag, "_mret"}, 32'(bus.mstatus_mret_o), 1);
    chk({tag, "_flush"}, 32'(bus.flush_o), 1);
    tick();
    bus.mstatus_mie_i = 1'b1;   // CSR file: MIE <= MPIE
    @(negedge clk_i);
    chk({tag, "_post"}, 32'(bus.jmp_o | bus.mstatus_mret_o), 0);
  endtask

  task automatic do_irq(input string tag, input bit raise, input logic [2:0] lines,
                        input logic [31:0] mie, input int drain, input logic [31:0] npc,
                        input bit drop, input bit exc_ovr, input logic [4:0] ec,
                        input logic [31:0] epc_exc);
    int          cyc;
    logic [4:0]  code;
    logic [31:0] cause, epc, tgt;
    code = exp_irq_code(lines, mie);
    tick();
    bus.mie_i = mie; bus.mstatus_mie_i = 1'b1; bus.pipe_empty_i = 1'b0;
    if (raise) set_lines(lines);
    cyc = 0;
    @(negedge clk_i);
    while (bus.stall_fetch_o !== 1'b1 && cyc < 60) begin tick(); @(negedge clk_i); cyc++; end
    chk({tag, "_drain"}, 32'(bus.stall_fetch_o), 1);
    if (raise) begin
      chk({tag, "_irq_lat"}, cyc, SYNC + 1);
      chk({tag, "_mip"}, bus.mip_o, exp_mip(lines));
    end
    for (int i = 0; i < drain; i++) begin
      tick();
      if (drop && i == 0) set_lines(3'b000);
      @(negedge clk_i);
      chk({tag, "_hold"}, 32'(bus.stall_fetch_o), 1);
      chk({tag, "_hold_we"}, 32'(bus.mepc_we_o), 0);
    end
    tick();
    if (exc_ovr) begin
      bus.exc_i = 1'b1; bus.exc_cause_i = ec; bus.exc_pc_i = epc_exc;
      cause = 32'(ec); epc = epc_exc; tgt = exp_target(bus.mtvec_i, 1'b0, ec);
    end else begin
      bus.pipe_empty_i = 1'b1; bus.next_pc_i = npc;
      cause = 32'h8000_0000 | 32'(code); epc = npc; tgt = exp_target(bus.mtvec_i, 1'b1, code);
    end
    @(negedge clk_i);
    expect_trap(tag, cause, epc, tgt, 1);
  endtask

  task automatic clear_irqs();
    tick();
    set_lines(3'b000);
    bus.pipe_empty_i = 1'b0;
    repeat (SYNC + 1) tick();
  endtask

  task automatic mie_off_check(input string tag);
    tick();
    bus.mstatus_mie_i = 1'b0; bus.mie_i = 32'h888; set_lines(3'b111);
    repeat (SYNC + 1) tick();
    @(negedge clk_i);
    chk({tag, "_mip"}, bus.mip_o, 32'h888);
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk_i);
      chk({tag, "_idle"}, 32'(bus.stall_fetch_o | bus.mepc_we_o | bus.jmp_o), 0);
    end
    clear_irqs();
  endtask

  // Strobe data must be zero whenever the strobe is low.
  always @(negedge clk_i) begin
    if (rstn_i) begin
      if (!bus.jmp_o)       chk("jaddr_quiet", bus.jmp_addr_o, 0);
      if (!bus.mepc_we_o)   chk("mepc_quiet", bus.mepc_o, 0);
      if (!bus.mcause_we_o) chk("mcause_quiet", bus.mcause_o, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  lines, sel;
    logic [31:0] mie, mtvec;
    int          kind;

    bus.irq_ext_i = 0; bus.irq_sw_i = 0; bus.irq_tmr_i = 0;
    bus.mstatus_mie_i = 0; bus.mie_i = 0; bus.mtvec_i = 0; bus.mepc_i = 0;
    bus.exc_i = 0; bus.exc_cause_i = 0; bus.exc_pc_i = 0; bus.mret_i = 0;
    bus.next_pc_i = 0; bus.pipe_empty_i = 0;

    // reset state
    repeat (3) @(negedge clk_i);
    chk("rst_ctrl", 32'({bus.stall_fetch_o, bus.flush_o, bus.jmp_o, bus.mepc_we_o,
                         bus.mcause_we_o, bus.mstatus_trap_o, bus.mstatus_mret_o}), 0);
    chk("rst_mip", bus.mip_o, 0);
    rstn_i = 1'b1;

    // external irq, direct mode, drain 3 cycles
    bus.mtvec_i = 32'h0000_1000;
    do_irq("ext", 1, 3'b100, 32'h800, 3, 32'h0000_0200, 0, 0, 0, 0);
    clear_irqs();
    do_mret("ext_ret", 32'h0000_0204);

    // timer irq, vectored then direct
    bus.mtvec_i = 32'h0010_0001;
    do_irq("tmr_vec", 1, 3'b010, 32'h080, 1, 32'h0000_0300, 0, 0, 0, 0);
    clear_irqs();
    do_mret("tmr_vec_ret", 32'h0000_0300);
    bus.mtvec_i = 32'h0010_0000;
    do_irq("tmr_dir", 1, 3'b010, 32'h080, 0, 32'h0000_0310, 0, 0, 0, 0);
    clear_irqs();
    do_mret("tmr_dir_ret", 32'h0000_0310);

    // vector add wraps past 2^32
    bus.mtvec_i = 32'hFFFF_FFF1;
    do_irq("wrap", 1, 3'b100, 32'h800, 0, 32'h0000_0400, 0, 0, 0, 0);
    clear_irqs();
    do_mret("wrap_ret", 32'h0000_0400);

    // exception in the same cycle an enabled ext irq becomes visible
    bus.mtvec_i = 32'h0000_2001;
    tick();
    bus.mie_i = 32'h800; bus.mstatus_mie_i = 1'b1; set_lines(3'b100);
    tick();
    do_exc("exc_vs_irq", 5'd2, 32'h0000_0040);
    clear_irqs();
    do_mret("exc_ret", 32'h0000_0044);

    // all three pending: MEI first, then MSI after MRET
    do_irq("all_mei", 1, 3'b111, 32'h888, 2, 32'h0000_0500, 0, 0, 0, 0);
    tick(); set_lines(3'b011); repeat (SYNC + 1) tick();
    do_mret("all_ret", 32'h0000_0084);
    do_irq("all_msi", 0, 3'b011, 32'h888, 1, 32'h0000_0084, 0, 0, 0, 0);
    clear_irqs();
    do_mret("msi_ret", 32'h0000_0088);

    // global enable off
    mie_off_check("mie_off");

    // async reset while in SAVE
    bus.mstatus_mie_i = 1'b0;
    tick();
    bus.exc_i = 1'b1; bus.exc_cause_i = 5'd4; bus.exc_pc_i = 32'h0000_0600;
    tick(); @(negedge clk_i);
    chk("rst_in_save", 32'(bus.mepc_we_o), 1);
    #1 rstn_i = 1'b0;
    #1;
    chk("rst_async_ctrl", 32'({bus.stall_fetch_o, bus.flush_o, bus.jmp_o, bus.mepc_we_o,
                               bus.mcause_we_o, bus.mstatus_trap_o, bus.mstatus_mret_o}), 0);
    chk("rst_async_data", bus.mepc_o | bus.mcause_o | bus.jmp_addr_o | bus.mip_o, 0);
    tick(); tick();
    @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); @(negedge clk_i);
      chk("rst_no_strobe", 32'({bus.mepc_we_o, bus.mcause_we_o, bus.jmp_o, bus.stall_fetch_o}), 0);
    end
    do_mret("rst_ret", 32'h0000_0700);

    // randomized scenarios
    for (int n = 0; n < 40; n++) begin
      mtvec = $urandom() & 32'hFFFF_FFFC;
      mtvec[0] = 1'($urandom_range(0, 1));
      bus.mtvec_i = mtvec;
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          do_exc("r_exc", 5'($urandom_range(0, 15)), $urandom() & 32'hFFFF_FFFC);
          do_mret("r_exc_ret", $urandom() & 32'hFFFF_FFFC);
        end
        1: begin
          sel   = 3'($urandom_range(1, 7));
          lines = 3'($urandom_range(1, 7));
          while ((lines & sel) == 3'b000) lines = 3'($urandom_range(1, 7));
          mie = ($urandom() & ~32'h888) | exp_mip(sel);
          do_irq("r_irq", 1, lines, mie, $urandom_range(0, 4), $urandom() & 32'hFFFF_FFFC,
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 5'($urandom_range(0, 15)), $urandom() & 32'hFFFF_FFFC);
          clear_irqs();
          do_mret("r_irq_ret", $urandom() & 32'hFFFF_FFFC);
        end
        2: do_mret("r_mret", $urandom());
        default: mie_off_check("r_mie_off");
      endcase
    end

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
